// File: rtl/hex_anim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_anim_pkg
// Brief    : Shared state encoding, segment indices and helpers for the
//            HEX ring animation controller.
// Revision : 1.0 - initial release
// ============================================================================
package hex_anim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [2:0] SEG_A = 3'd0;
    localparam logic [2:0] SEG_B = 3'd1;
    localparam logic [2:0] SEG_C = 3'd2;
    localparam logic [2:0] SEG_D = 3'd3;
    localparam logic [2:0] SEG_E = 3'd4;
    localparam logic [2:0] SEG_F = 3'd5;
    localparam logic [2:0] SEG_G = 3'd6;

    localparam logic [6:0] BLANK = 7'h7F;

    // Location of one lit segment on the ring: which digit and which segment.
    typedef struct packed {
        logic [2:0] digit;
        logic [2:0] seg;
    } seg_loc_t;

    function automatic logic [6:0] seg_mask(input logic [2:0] seg);
        seg_mask = 7'b000_0001 << seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : step_prescaler
// Brief    : Divides clk down to a one-cycle animation step tick every DIV
//            enabled cycles; holds its count while disabled.
// Revision : 1.0 - initial release
// ============================================================================
module step_prescaler #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             c_CW  = $clog2(DIV);
    localparam logic [c_CW-1:0] c_TOP = c_CW'(DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_TOP) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == c_TOP);

endmodule
`default_nettype wire

// File: rtl/hex_ring_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_ring_anim_ctrl
// Brief    : Running-segment animation around the outer ring of NUM_DIG
//            active-low 7-segment digits, with start/pause/stop control.
//            Optional macro HEX_TRAIL_EN also lights the trailing segment.
// Revision : 1.0 - initial release
// ============================================================================
module hex_ring_anim_ctrl
    import hex_anim_pkg::*;
#(
    parameter int NUM_DIG = 4,
    parameter int DIV     = 50_000_000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              dir,
    output logic [7*NUM_DIG-1:0]              segs,
    output logic                              running,
    output logic [$clog2(2*NUM_DIG+4)-1:0]    pos,
    output logic                              lap
);

    localparam int              c_L      = 2*NUM_DIG + 4;
    localparam int              c_PW     = $clog2(c_L);
    localparam logic [c_PW-1:0] c_LAST   = c_PW'(c_L - 1);
    localparam logic [c_PW-1:0] c_N      = c_PW'(NUM_DIG);
    localparam logic [c_PW-1:0] c_N_M1   = c_PW'(NUM_DIG - 1);
    localparam logic [c_PW-1:0] c_P_C    = c_PW'(NUM_DIG + 1);
    localparam logic [c_PW-1:0] c_P_DEND = c_PW'(2*NUM_DIG + 1);
    localparam logic [c_PW-1:0] c_P_E    = c_PW'(2*NUM_DIG + 2);

    state_t            r_state, w_state_nxt;
    logic [c_PW-1:0]   r_pos, w_pos_nxt;
    logic              r_lap, w_lap_nxt;
    logic              r_start_d, r_stop_d;
    logic              w_start_rise, w_stop_rise;
    logic              w_tick, w_presc_en, w_presc_clr;
    logic [c_PW-1:0]   w_pos_fwd, w_pos_bwd;
    seg_loc_t          w_head;

    assign w_start_rise = start & ~r_start_d;
    assign w_stop_rise  = stop  & ~r_stop_d;

    assign w_pos_fwd = (r_pos == c_LAST) ? '0 : r_pos + 1'b1;
    assign w_pos_bwd = (r_pos == '0) ? c_LAST : r_pos - 1'b1;

    assign w_presc_en  = (r_state == RUN);
    assign w_presc_clr = (r_state == IDLE);

    step_prescaler #(
        .DIV   (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (w_presc_en),
        .clr   (w_presc_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pos     <= '0;
            r_lap     <= 1'b0;
            r_start_d <= 1'b0;
            r_stop_d  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pos     <= w_pos_nxt;
            r_lap     <= w_lap_nxt;
            r_start_d <= start;
            r_stop_d  <= stop;
        end
    end

    // Stop is checked first everywhere so it wins over a simultaneous start.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_lap_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_stop_rise && w_start_rise) begin
                    w_state_nxt = RUN;
                    w_pos_nxt   = '0;
                end
            end
            RUN: begin
                if (w_tick) begin
                    w_pos_nxt = dir ? w_pos_bwd : w_pos_fwd;
                    w_lap_nxt = dir ? (r_pos == '0) : (r_pos == c_LAST);
                end
                if (w_stop_rise) begin
                    w_state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (w_stop_rise) begin
                    w_state_nxt = IDLE;
                    w_pos_nxt   = '0;
                end else if (w_start_rise) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pos_nxt   = '0;
            end
        endcase
    end

    // Ring walk: top edge left-to-right, down the right digit, bottom edge
    // right-to-left, then up the left digit.
    function automatic seg_loc_t decode(input logic [c_PW-1:0] p);
        seg_loc_t        loc;
        logic [c_PW-1:0] t;
        t = '0;
        if (p < c_N) begin
            t = p;
            loc.seg = SEG_A;
        end else if (p == c_N) begin
            t = c_N_M1;
            loc.seg = SEG_B;
        end else if (p == c_P_C) begin
            t = c_N_M1;
            loc.seg = SEG_C;
        end else if (p <= c_P_DEND) begin
            t = c_P_DEND - p;
            loc.seg = SEG_D;
        end else if (p == c_P_E) begin
            loc.seg = SEG_E;
        end else begin
            loc.seg = SEG_F;
        end
        loc.digit = 3'(t);
        return loc;
    endfunction

    assign w_head = decode(r_pos);

`ifdef HEX_TRAIL_EN
    logic [c_PW-1:0] w_trail_pos;
    seg_loc_t        w_trail;
    assign w_trail_pos = dir ? w_pos_fwd : w_pos_bwd;
    assign w_trail     = decode(w_trail_pos);
`endif

    for (genvar k = 0; k < NUM_DIG; k++) begin : g_digit
        localparam logic [2:0] c_K = 3'(k);
        logic [6:0] w_dig;
        always_comb begin
            w_dig = BLANK;
            if (r_state != IDLE) begin
                if (w_head.digit == c_K) begin
                    w_dig = w_dig & ~seg_mask(w_head.seg);
                end
`ifdef HEX_TRAIL_EN
                if (w_trail.digit == c_K) begin
                    w_dig = w_dig & ~seg_mask(w_trail.seg);
                end
`endif
            end
        end
        assign segs[7*k +: 7] = w_dig;
    end

    assign running = (r_state == RUN);
    assign pos     = r_pos;
    assign lap     = r_lap;

endmodule
`default_nettype wire
